// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing defaults.
// The transmitter uses the same bit-timing constant.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } uart_state_e;

    // Clock-count terminal value; one bit period is CYCLES_PER_BIT_DEF+1 clocks.
    localparam int CYCLES_PER_BIT_DEF = 434;
    localparam int CNT_W              = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// The reset value is a parameter, so an idle line level can be preloaded.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The start bit is validated at half a bit, and each data bit
// and the stop bit are sampled at mid-bit, LSB first. Done and error pulses last one cycle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEF,
    parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Rx,
    output logic [7:0] o_Data,
    output logic       o_fDone,
    output logic       o_fErr,
    output logic       o_fBusy
);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT);

    logic rx_s;
    logic rx_d_q;
    logic fall;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .d_i   (i_Rx),
        .q_o   (rx_s)
    );

    // The extra delay flop gives an edge detector, so a held-low line cannot re-arm reception.
    assign fall = rx_d_q & ~rx_s;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            rx_d_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rx_d_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Leaving at stop mid-bit leaves half a bit to catch a back-to-back start edge.
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_Data  = data_q;
    assign o_fDone = done_q;
    assign o_fErr  = err_q;
    assign o_fBusy = (state_q != IDLE);

endmodule
